ksa_swap: RTL and testbench

- Key-scheduling stage of the RC4 decryption datapath; sits directly downstream of mem_write.
- mem_write fills the 256x8 S-memory with S[i]=i. Once that is done, this block takes ownership of the same memory port.
- It runs the RC4 key-scheduling swap loop for i=0..255: j = j + S[i] + key[i mod KEY_LEN], then swap S[i] and S[j].
- It then hands the memory to the PRGA/decrypt stage via done.

---
 rtl/ksa_swap_if.sv | 23 ++
 rtl/ksa_swap.sv | 120 ++++++++++++
 tb/tb_ksa_swap.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ksa_swap_if.sv
// rtl/ksa_swap_if.sv - control and S-memory port bundle for the RC4 key-scheduling stage
interface ksa_swap_if #(
    parameter int KEY_W = 24
);
    logic             start;
    logic [KEY_W-1:0] secret_key;
    logic [7:0]       q;
    logic [7:0]       address;
    logic [7:0]       data;
    logic             wren;
    logic             busy;
    logic             done;

    modport slave (
        input  start, secret_key, q,
        output address, data, wren, busy, done
    );

    modport master (
        output start, secret_key, q,
        input  address, data, wren, busy, done
    );
endinterface

// File: rtl/ksa_swap.sv
// rtl/ksa_swap.sv - RC4 key-scheduling swap loop over the shared 256x8 S-memory
// Optional KSA_SKIP_SELF_SWAP_EN: iterations with j==i skip both write cycles.
module ksa_swap #(
    parameter int KEY_LEN = 3,
    parameter int KEY_W   = 24
) (
    input  logic      clk,
    input  logic      rst,
    ksa_swap_if.slave bus
);
    localparam int KIW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_SI, WR_SJ, DONE
    } state_t;

    state_t         state, state_n;
    logic [7:0]     i, j, si, sj;
    logic [KIW-1:0] k;
    logic [7:0]     key_bytes [KEY_LEN];
    logic [7:0]     key_byte;
    logic           advance;
    logic           skip;

    for (genvar g = 0; g < KEY_LEN; g++) begin : g_key
        assign key_bytes[g] = bus.secret_key[KEY_W-1-8*g -: 8];
    end
    assign key_byte = key_bytes[k];

`ifdef KSA_SKIP_SELF_SWAP_EN
    assign skip = (state == WAIT_SJ) && (j == i);
`else
    assign skip = 1'b0;
`endif

    // End of an iteration: either the second write or a skipped self-swap.
    assign advance = (state == WR_SJ) || skip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= '0;
            si    <= 8'd0;
            sj    <= 8'd0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        i <= 8'd0;
                        j <= 8'd0;
                        k <= '0;
                    end
                end
                WAIT_SI: begin
                    si <= bus.q;
                    j  <= j + bus.q + key_byte;
                end
                WAIT_SJ: sj <= bus.q;
                default: ;
            endcase
            if (advance && (i != 8'hFF)) begin
                i <= i + 8'd1;
                k <= (k == KIW'(KEY_LEN - 1)) ? '0 : k + 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        bus.address = 8'd0;
        bus.data    = 8'd0;
        bus.wren    = 1'b0;
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_n = RD_SI;
            end
            RD_SI: begin
                bus.address = i;
                state_n     = WAIT_SI;
            end
            WAIT_SI: begin
                bus.address = i;
                state_n     = RD_SJ;
            end
            RD_SJ: begin
                bus.address = j;
                state_n     = WAIT_SJ;
            end
            WAIT_SJ: begin
                bus.address = j;
                if (skip) state_n = (i == 8'hFF) ? DONE : RD_SI;
                else      state_n = WR_SI;
            end
            WR_SI: begin
                bus.address = i;
                bus.data    = sj;
                bus.wren    = 1'b1;
                state_n     = WR_SJ;
            end
            WR_SJ: begin
                bus.address = j;
                bus.data    = si;
                bus.wren    = 1'b1;
                state_n     = (i == 8'hFF) ? DONE : RD_SI;
            end
            DONE: begin
                bus.busy = 1'b0;
                bus.done = 1'b1;
                if (bus.start) state_n = RD_SI;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ksa_swap.sv
// tb/tb_ksa_swap.sv - self-checking bench for ksa_swap with a synchronous S-memory model
module tb_ksa_swap;
    localparam int KEY_LEN = 3;
    localparam int KEY_W   = 24;
`ifdef KSA_SKIP_SELF_SWAP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ksa_swap_if #(.KEY_W(KEY_W)) bus ();
    ksa_swap #(.KEY_LEN(KEY_LEN), .KEY_W(KEY_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [256];
    logic       init_req = 1'b0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (bus.wren) begin
            mem[bus.address] <= bus.data;
        end
        bus.q <= mem[bus.address];
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [23:0] key;
        bit          hold;
        int          it0;
        logic [7:0]  j0;
        int          it1;
        logic [7:0]  j1;
    } vec_t;

    wr_t        exp_q[$];
    wr_t        mon_w;
    logic [7:0] ms [256];
    int         self_cnt;
    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;
    int         nw_cnt;
    int         busy_cnt;
    logic [7:0] dut_j [256];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_model(input logic [23:0] key);
        logic [7:0] jj, kb, t;
        exp_q.delete();
        self_cnt = 0;
        jj = 8'd0;
        for (int a = 0; a < 256; a++) ms[a] = 8'(a);
        for (int ii = 0; ii < 256; ii++) begin
            kb = key[23 - 8*(ii % KEY_LEN) -: 8];
            jj = jj + ms[ii] + kb;
            if (jj == 8'(ii)) self_cnt++;
            if (!(SKIP && jj == 8'(ii))) begin
                exp_q.push_back('{addr: 8'(ii), data: ms[jj]});
                exp_q.push_back('{addr: jj, data: ms[ii]});
            end
            t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.busy) begin
            busy_cnt++;
            if (bus.wren) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("wr_addr", int'(bus.address), int'(mon_w.addr));
                    check("wr_data", int'(bus.data), int'(mon_w.data));
                end
            end else begin
                if ((nw_cnt % 4) == 2 && (nw_cnt / 4) < 256) dut_j[nw_cnt / 4] = bus.address;
                nw_cnt++;
            end
        end
    end

    task automatic init_mem();
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic start_pass(input logic [23:0] key);
        run_model(key);
        init_mem();
        nw_cnt   = 0;
        busy_cnt = 0;
        mon_en   = 1'b1;
        bus.secret_key = key;
        bus.start = 1'b1;
    endtask

    task automatic run_pass(input vec_t v);
        int n, exp_busy;
        start_pass(v.key);
        exp_busy = 4*256 + 2*(256 - (SKIP ? self_cnt : 0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!v.hold) bus.start = 1'b0;
        end while (!bus.done && n < 5000);
        check("done_latency", n, exp_busy + 1);
        check("busy_cycles", busy_cnt, exp_busy);
        check("writes_left", exp_q.size(), 0);
        for (int a = 0; a < 256; a++) check("final_s", int'(mem[a]), int'(ms[a]));
        check("j_hand0", int'(dut_j[v.it0]), int'(v.j0));
        check("j_hand1", int'(dut_j[v.it1]), int'(v.j1));
        if (v.hold) begin
            @(negedge clk);
            check("restart_done", int'(bus.done), 0);
            check("restart_busy", int'(bus.busy), 1);
            bus.start = 1'b0;
            mon_en = 1'b0;
            rst = 1'b0;
            @(negedge clk) rst = 1'b1;
        end
        mon_en = 1'b0;
        exp_q.delete();
    endtask

    vec_t vecs [4];

    initial begin
        int n;
        vecs[0] = '{key: 24'h000000, hold: 1'b1, it0: 0, j0: 8'h00, it1: 1, j1: 8'h01};
        vecs[1] = '{key: 24'h000249, hold: 1'b0, it0: 1, j0: 8'h03, it1: 3, j1: 8'h4F};
        vecs[2] = '{key: 24'hA53C7E, hold: 1'b0, it0: 0, j0: 8'hA5, it1: 1, j1: 8'hE2};
        vecs[3] = '{key: 24'hFFFFFF, hold: 1'b0, it0: 0, j0: 8'hFF, it1: 1, j1: 8'hFF};

        bus.start = 1'b0;
        bus.secret_key = '0;
        #12;
        check("rst_address", int'(bus.address), 0);
        check("rst_data", int'(bus.data), 0);
        check("rst_wren", int'(bus.wren), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_done", int'(bus.done), 0);

        for (int v = 0; v < 4; v++) run_pass(vecs[v]);

        // Abort a pass mid-iteration around i=100 with an asynchronous reset.
        start_pass(24'h000249);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
        end while (!(nw_cnt >= 400 && bus.wren) && n < 5000);
        check("abort_reached", int'(n < 5000), 1);
        #1 rst = 1'b0;
        #1;
        check("abort_wren", int'(bus.wren), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_address", int'(bus.address), 0);
        check("abort_data", int'(bus.data), 0);
        mon_en = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", int'(bus.busy), 0);
        run_pass(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
